// File: rtl/uart_tx_queue_ctrl_pkg.sv
// rtl/uart_tx_queue_ctrl_pkg.sv - shared UART TX register bit positions and FSM encodings
// Purpose: constants shared by the UART TX queue, its FIFO and the SoC IO decoder.
// Ports: none (package).
package uart_tx_queue_ctrl_pkg;

  localparam int DATA_W = 8;

  // Status word bit positions; count occupies [7:0].
  localparam int STAT_OVF_BIT  = 10;
  localparam int STAT_BUSY_BIT = 9;
  localparam int STAT_IDLE_BIT = 8;

  // Control word bit positions.
  localparam int CTRL_FLUSH_BIT  = 0;
  localparam int CTRL_CLROVF_BIT = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic ovf, input logic busy,
                                              input logic idle, input logic [7:0] count);
    logic [31:0] s;
    s = 32'h0;
    s[7:0] = count;
    s[STAT_IDLE_BIT] = idle;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_OVF_BIT]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with push/pop/flush for the UART TX queue
// Purpose: DEPTH = 1<<ADDR_W entry FIFO, pointers wrap modulo DEPTH.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, push_data       write strobe and byte; accepted when not full or popping
//   pop, pop_data         read advance and combinational head byte
//   flush                 empties the FIFO at the next edge; wins over push
//   count, full, empty    occupancy
module uart_tx_fifo
  import uart_tx_queue_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full     = (count_q == DEPTH[ADDR_W:0]);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign push_ok = push & (~full | pop) & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_queue_ctrl.sv
// rtl/uart_tx_queue_ctrl.sv - UART transmit queue controller with status word
// Purpose: queues CPU-written bytes and feeds them to the UART emitter over tx_valid/tx_ready.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   wr_en, wr_data         push strobe and byte from the UART data word
//   ctrl_wr, ctrl_wdata    control strobe; [0] flush, [1] clear overflow
//   status                 {21'b0, ovf, busy, idle, count[7:0]}
//   tx_data, tx_valid      byte presented to the emitter
//   tx_ready               emitter ready
module uart_tx_queue_ctrl
  import uart_tx_queue_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ctrl_wr,
  input  logic [1:0]        ctrl_wdata,
  output logic [31:0]       status,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  tx_state_e         state_q, state_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              ovf_q, ovf_d;

  logic              flush, clr_ovf, pop, avail, overflow;
  logic [DATA_W-1:0] fifo_data;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_full, fifo_empty;

  assign flush   = ctrl_wr & ctrl_wdata[CTRL_FLUSH_BIT];
  assign clr_ovf = ctrl_wr & ctrl_wdata[CTRL_CLROVF_BIT];

  // Nothing is loaded from a FIFO that is being flushed this cycle.
  assign avail = ~fifo_empty & ~flush;

  uart_tx_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_valid_d = 1'b0;
        if (avail) begin
          pop        = 1'b1;
          tx_data_d  = fifo_data;
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // tx_data only moves on a completed handshake; the next byte is
        // loaded in the same cycle so consecutive bytes have no gap.
        if (tx_ready) begin
          if (avail) begin
            pop       = 1'b1;
            tx_data_d = fifo_data;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A flushed write is discarded, not counted as an overflow.
  assign overflow = wr_en & fifo_full & ~pop & ~flush;

  always_comb begin
    ovf_d = ovf_q;
    if (overflow)     ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign status   = pack_status(ovf_q, fifo_full,
                                fifo_empty & (state_q == ST_IDLE) & tx_ready,
                                8'(fifo_count));

endmodule
